dma_copy_engine: RTL

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_if.sv | 28 ++
 rtl/dma_fifo.sv | 65 ++++++
 rtl/dma_copy_engine.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg -- shared definitions for the DMA copy engine.
//   dma_state_t        : engine FSM states (IDLE, RUN, DONE)
//   FIFO_DEPTH_DEFAULT : default number of words buffered between read and write sides
//   ADDR_INC           : address step per word
// Configuration macro: DMA_BYTE_ADDR_EN
//   defined   -> byte addressing, 4 bytes per 32-bit word
//   undefined -> word addressing, step of 1
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_t;

  localparam int FIFO_DEPTH_DEFAULT = 4;

`ifdef DMA_BYTE_ADDR_EN
  // Byte addresses: one 32-bit word spans four byte addresses.
  localparam logic [31:0] ADDR_INC = 32'd4;
`else
  localparam logic [31:0] ADDR_INC = 32'd1;
`endif

endpackage

// File: rtl/dma_if.sv
// dma_if -- read-master and write-master bus of the DMA copy engine.
//   rd_req/rd_addr -> memory, rd_ack/rd_data <- memory
//   wr_req/wr_addr/wr_data -> memory, wr_ack <- memory
// A request and its address/data are held until the matching ack is high
// in a cycle; that cycle completes the transfer.
// modport master : engine side, modport slave : memory side.
interface dma_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  rd_req;
  logic [31:0]           rd_addr;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [31:0]           wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ack, rd_data, wr_ack
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ack, rd_data, wr_ack
  );
endinterface

// File: rtl/dma_fifo.sv
// dma_fifo -- small synchronous FIFO between the read and write sides.
//   clock, reset_n : clock, synchronous active-low reset
//   clear          : synchronous flush (pointers and count to zero)
//   push/push_data : write one word (ignored when full)
//   pop            : drop the head word (ignored when empty)
//   head           : current head word, valid whenever empty is low
//   full/empty/count : occupancy status
// The head is read combinationally so a word pushed in one cycle is
// presented to the write side in the very next cycle.
module dma_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/dma_copy_engine.sv
// dma_copy_engine -- copies iSize words from iBase_Rd_add to iBase_Wr_add.
//   clock, reset_n       : clock, synchronous active-low reset
//   iBase_Rd_add/Wr_add  : source/destination start address (sampled at start)
//   iSize                : length in words (sampled at start)
//   iStart               : start level; only a rising edge seen in IDLE starts a copy
//   bus (dma_if.master)  : read master and write master
//   oBusy                : high in RUN and DONE
//   oDone                : one-cycle pulse in DONE
// Configuration macro: DMA_BYTE_ADDR_EN (byte addressing, see dma_pkg).
// Reads and writes overlap through dma_fifo: the read side keeps the FIFO
// topped up (one read outstanding at a time) while the write side drains it.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] iBase_Rd_add,
  input  logic [31:0] iBase_Wr_add,
  input  logic [31:0] iSize,
  input  logic        iStart,
  dma_if.master       bus,
  output logic        oBusy,
  output logic        oDone
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_t            state_reg;
  logic                  start_reg;
  logic                  start_prev_reg;
  logic [31:0]           rd_addr_reg;
  logic [31:0]           wr_addr_reg;
  logic [31:0]           size_reg;
  logic [31:0]           rd_cnt_reg;
  logic [31:0]           wr_cnt_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic                  start_edge;
  logic                  in_run;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  fifo_clear;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;

  assign start_edge = start_reg && !start_prev_reg;
  assign in_run     = (state_reg == RUN);
  assign fifo_clear = (state_reg == IDLE) && start_edge;

  // rd_req is the outstanding read itself, so "occupancy + outstanding" is
  // just the occupancy check. Neither term can change while a read waits
  // for its ack, which keeps rd_req and rd_addr stable.
  assign bus.rd_req  = in_run && (rd_cnt_reg < size_reg) && (fifo_count < CW'(FIFO_DEPTH));
  assign bus.rd_addr = rd_addr_reg;
  assign bus.wr_req  = in_run && !fifo_empty;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = bus.wr_req ? fifo_head : '0;

  assign rd_fire = bus.rd_req && bus.rd_ack && !fifo_full;
  assign wr_fire = bus.wr_req && bus.wr_ack;

  assign oBusy = busy_reg;
  assign oDone = done_reg;

  dma_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (fifo_clear),
    .push      (rd_fire),
    .push_data (bus.rd_data),
    .pop       (wr_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      start_reg      <= 1'b0;
      start_prev_reg <= 1'b0;
      rd_addr_reg    <= '0;
      wr_addr_reg    <= '0;
      size_reg       <= '0;
      rd_cnt_reg     <= '0;
      wr_cnt_reg     <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      start_reg      <= iStart;
      start_prev_reg <= start_reg;
      done_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            rd_addr_reg <= iBase_Rd_add;
            wr_addr_reg <= iBase_Wr_add;
            size_reg    <= iSize;
            rd_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
            busy_reg    <= 1'b1;
            if (iSize == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (rd_fire) begin
            rd_addr_reg <= rd_addr_reg + ADDR_INC;
            rd_cnt_reg  <= rd_cnt_reg + 32'd1;
          end
          if (wr_fire) begin
            wr_addr_reg <= wr_addr_reg + ADDR_INC;
            wr_cnt_reg  <= wr_cnt_reg + 32'd1;
            // Final write: DONE occupies the next cycle, FIFO already empty.
            if (wr_cnt_reg + 32'd1 == size_reg) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end
endmodule
